// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep scheduler.
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_MEAS   = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  localparam int PTS_W_DEF    = 16;
  localparam int SETTLE_W_DEF = 24;

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter shared by the settle dwell and the measurement timeout.
module sweep_timer #(
  parameter int W = 24
) (
  input  logic         dac_clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge dac_clk) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sweep_sched.sv
// Frequency sweep scheduler: steps a DDS frequency word, dwells, then handshakes a measurement per point.
// Optional measurement timeout enabled by defining SWEEP_SCHED_TIMEOUT_EN.
module sweep_sched
  import dds_pkg::*;
#(
  parameter int PTS_W      = PTS_W_DEF,
  parameter int SETTLE_W   = SETTLE_W_DEF,
  parameter int TMO_CYCLES = 1000000
) (
  input  logic                dac_clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         cfg_fword_start,
  input  logic [31:0]         cfg_fword_step,
  input  logic [PTS_W-1:0]    cfg_num_points,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic                meas_ack,
  output logic [31:0]         fword_out,
  output logic                param_wen,
  output logic                meas_req,
  output logic [PTS_W-1:0]    point_idx,
  output logic                busy,
  output logic                done,
  output logic                tmo_err
);

  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  localparam int TMR_W = (TMO_W > SETTLE_W) ? TMO_W : SETTLE_W;

  sweep_state_t        state_reg, state_next;
  logic [31:0]         fword_reg, fword_next;
  logic [PTS_W-1:0]    idx_reg, idx_next;
  logic                param_wen_reg, param_wen_next;
  logic [31:0]         step_reg;
  logic [PTS_W-1:0]    num_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic                latch_cfg;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_load_val;
  logic                tmr_dec;
  logic                tmr_zero;

`ifdef SWEEP_SCHED_TIMEOUT_EN
  logic                tmo_err_reg, tmo_err_next;
`endif

  sweep_timer #(
    .W(TMR_W)
  ) u_timer (
    .dac_clk  (dac_clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge dac_clk) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      fword_reg     <= '0;
      idx_reg       <= '0;
      param_wen_reg <= 1'b0;
      step_reg      <= '0;
      num_reg       <= '0;
      settle_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      fword_reg     <= fword_next;
      idx_reg       <= idx_next;
      param_wen_reg <= param_wen_next;
      if (latch_cfg) begin
        step_reg   <= cfg_fword_step;
        num_reg    <= cfg_num_points;
        settle_reg <= cfg_settle;
      end
    end
  end

`ifdef SWEEP_SCHED_TIMEOUT_EN
  always_ff @(posedge dac_clk) begin
    if (!rstn) begin
      tmo_err_reg <= 1'b0;
    end else begin
      tmo_err_reg <= tmo_err_next;
    end
  end
`endif

  always_comb begin
    state_next     = state_reg;
    fword_next     = fword_reg;
    idx_next       = idx_reg;
    param_wen_next = 1'b0;
    latch_cfg      = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_val   = '0;
    tmr_dec        = 1'b0;
`ifdef SWEEP_SCHED_TIMEOUT_EN
    tmo_err_next   = tmo_err_reg;
`endif

    // Abort outranks every other request, including a same-cycle ack or start.
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && (cfg_num_points != '0)) begin
            latch_cfg      = 1'b1;
            state_next     = ST_SETTLE;
            fword_next     = cfg_fword_start;
            idx_next       = '0;
            param_wen_next = 1'b1;
            tmr_load       = 1'b1;
            tmr_load_val   = TMR_W'(cfg_settle);
`ifdef SWEEP_SCHED_TIMEOUT_EN
            tmo_err_next   = 1'b0;
`endif
          end
        end

        ST_SETTLE: begin
          if (tmr_zero) begin
            state_next = ST_MEAS;
`ifdef SWEEP_SCHED_TIMEOUT_EN
            // Loaded with N-1 so the zero test fires on the N-th MEAS cycle.
            tmr_load     = 1'b1;
            tmr_load_val = TMR_W'(TMO_CYCLES - 1);
`endif
          end else begin
            tmr_dec = 1'b1;
          end
        end

        ST_MEAS: begin
          if (meas_ack) begin
            if (idx_reg == (num_reg - PTS_W'(1))) begin
              state_next = ST_DONE;
            end else begin
              state_next     = ST_SETTLE;
              fword_next     = fword_reg + step_reg;
              idx_next       = idx_reg + PTS_W'(1);
              param_wen_next = 1'b1;
              tmr_load       = 1'b1;
              tmr_load_val   = TMR_W'(settle_reg);
            end
          end
`ifdef SWEEP_SCHED_TIMEOUT_EN
          else if (tmr_zero) begin
            state_next   = ST_IDLE;
            tmo_err_next = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
`endif
        end

        ST_DONE: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign fword_out = fword_reg;
  assign param_wen = param_wen_reg;
  assign point_idx = idx_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign meas_req  = (state_reg == ST_MEAS);
  assign done      = (state_reg == ST_DONE);

`ifdef SWEEP_SCHED_TIMEOUT_EN
  assign tmo_err = tmo_err_reg;
`else
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_sched.sv
// Self-checking bench for sweep_sched: cycle-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_sweep_sched;

  localparam int PTS_W    = 16;
  localparam int SETTLE_W = 24;
  localparam int TMO      = 50;

  logic                dac_clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                meas_ack = 1'b0;
  logic [31:0]         cfg_fword_start = '0;
  logic [31:0]         cfg_fword_step = '0;
  logic [PTS_W-1:0]    cfg_num_points = '0;
  logic [SETTLE_W-1:0] cfg_settle = '0;
  logic [31:0]         fword_out;
  logic                param_wen;
  logic                meas_req;
  logic [PTS_W-1:0]    point_idx;
  logic                busy;
  logic                done;
  logic                tmo_err;

  int checks = 0;
  int errors = 0;

  sweep_sched #(
    .PTS_W(PTS_W),
    .SETTLE_W(SETTLE_W),
    .TMO_CYCLES(TMO)
  ) dut (
    .dac_clk         (dac_clk),
    .rstn            (rstn),
    .start           (start),
    .abort           (abort),
    .cfg_fword_start (cfg_fword_start),
    .cfg_fword_step  (cfg_fword_step),
    .cfg_num_points  (cfg_num_points),
    .cfg_settle      (cfg_settle),
    .meas_ack        (meas_ack),
    .fword_out       (fword_out),
    .param_wen       (param_wen),
    .meas_req        (meas_req),
    .point_idx       (point_idx),
    .busy            (busy),
    .done            (done),
    .tmo_err         (tmo_err)
  );

  always #5 dac_clk = ~dac_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs after the next rising edge, from the sweep rules.
  bit          m_valid = 0;
  bit          m_busy = 0, m_req = 0, m_wen = 0, m_done = 0, m_tmo = 0;
  logic [31:0] m_fword = '0, m_step = '0;
  int          m_idx = 0, m_num = 0, m_settle = 0;
  int          m_settle_left = 0, m_meas_cycles = 0;

  logic [31:0] wen_q[$];
  int          done_cnt = 0;

  task automatic model_step();
    bit was_done;
    was_done = m_done;
    m_wen  = 0;
    m_done = 0;
    if (!rstn) begin
      m_valid = 1; m_busy = 0; m_req = 0; m_tmo = 0;
      m_fword = '0; m_idx = 0; m_settle_left = 0;
    end else if (abort) begin
      m_busy = 0; m_req = 0;
    end else if (!m_busy) begin
      if (start && (int'(cfg_num_points) != 0)) begin
        m_step = cfg_fword_step; m_num = int'(cfg_num_points); m_settle = int'(cfg_settle);
        m_busy = 1; m_fword = cfg_fword_start; m_idx = 0; m_wen = 1; m_tmo = 0;
        m_settle_left = m_settle + 1;
      end
    end else if (was_done) begin
      m_busy = 0;
    end else if (m_settle_left > 0) begin
      m_settle_left--;
      if (m_settle_left == 0) begin
        m_req = 1;
        m_meas_cycles = 0;
      end
    end else if (m_req) begin
      m_meas_cycles++;
      if (meas_ack) begin
        m_req = 0;
        if (m_idx == m_num - 1) begin
          m_done = 1;
        end else begin
          m_fword = m_fword + m_step;
          m_idx++;
          m_wen = 1;
          m_settle_left = m_settle + 1;
        end
      end
`ifdef SWEEP_SCHED_TIMEOUT_EN
      else if (m_meas_cycles == TMO) begin
        m_tmo = 1; m_req = 0; m_busy = 0;
      end
`endif
    end
  endtask

  always @(negedge dac_clk) begin
    if (m_valid) begin
      check("busy", busy, m_busy);
      check("meas_req", meas_req, m_req);
      check("done", done, m_done);
      check("param_wen", param_wen, m_wen);
      check("fword_out", fword_out, m_fword);
      check("point_idx", point_idx, m_idx[PTS_W-1:0]);
      check("tmo_err", tmo_err, m_tmo);
    end
    if (param_wen === 1'b1) wen_q.push_back(fword_out);
    if (done === 1'b1) done_cnt++;
    model_step();
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge dac_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!meas_req && k < 200) begin
      tick();
      k++;
    end
    check(name, meas_req, 1'b1);
  endtask

  task automatic ack_one(input string name);
    wait_req(name);
    tick();
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] st,
                         input int np, input int se);
    cfg_fword_start = fs;
    cfg_fword_step  = st;
    cfg_num_points  = PTS_W'(np);
    cfg_settle      = SETTLE_W'(se);
  endtask

  task automatic clear_log();
    wen_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    int cnt;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_fword", fword_out, 32'h0);
    check("rst_idx", point_idx, 16'h0);
    check("rst_req", meas_req, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tmo", tmo_err, 1'b0);
    rstn = 1'b1;
    tick(2);

    // Three-point sweep; cfg changes after start must not leak in.
    set_cfg(32'h100, 32'h10, 3, 2);
    clear_log();
    pulse_start();
    check("s1_first_fword", fword_out, 32'h100);
    check("s1_first_wen", param_wen, 1'b1);
    set_cfg(32'h5555, 32'h999, 7, 9);
    for (int p = 0; p < 3; p++) ack_one("s1_req");
    wait_idle("s1_idle");
    check("s1_wen_count", wen_q.size(), 3);
    check("s1_fw0", wen_q.size() > 0 ? wen_q[0] : 32'hDEAD, 32'h100);
    check("s1_fw1", wen_q.size() > 1 ? wen_q[1] : 32'hDEAD, 32'h110);
    check("s1_fw2", wen_q.size() > 2 ? wen_q[2] : 32'hDEAD, 32'h120);
    check("s1_done_count", done_cnt, 1);
    tick(2);

    // Frequency-word wrap.
    set_cfg(32'hFFFF_FFF8, 32'h10, 2, 1);
    clear_log();
    pulse_start();
    for (int p = 0; p < 2; p++) ack_one("s2_req");
    wait_idle("s2_idle");
    check("s2_wrap_fw", wen_q.size() > 1 ? wen_q[1] : 32'hDEAD, 32'h0000_0008);
    check("s2_done_count", done_cnt, 1);
    tick(2);

    // Abort during the second measurement.
    set_cfg(32'h1000, 32'h100, 4, 3);
    clear_log();
    pulse_start();
    ack_one("s3_req1");
    wait_req("s3_req2");
    check("s3_idx_before", point_idx, 16'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s3_busy", busy, 1'b0);
    check("s3_req", meas_req, 1'b0);
    check("s3_idx_held", point_idx, 16'd1);
    check("s3_fword_held", fword_out, 32'h1100);
    tick(4);
    check("s3_no_done", done_cnt, 0);

    // Zero points is ignored; start while busy is ignored.
    set_cfg(32'h777, 32'h1, 0, 0);
    pulse_start();
    check("s4_zero_pts_busy", busy, 1'b0);
    tick(2);
    check("s4_zero_pts_idle", busy, 1'b0);
    set_cfg(32'h200, 32'h1, 3, 5);
    pulse_start();
    tick(2);
    set_cfg(32'hABC, 32'h2, 5, 0);
    pulse_start();
    check("s4_busy_fword", fword_out, 32'h200);
    check("s4_busy_wen", param_wen, 1'b0);
    check("s4_busy_state", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(2);

    // Zero settle: request two cycles after start, then abort beats ack.
    set_cfg(32'h50, 32'h4, 2, 0);
    clear_log();
    pulse_start();
    check("s5_c1_req", meas_req, 1'b0);
    tick();
    check("s5_c2_req", meas_req, 1'b1);
    abort = 1'b1;
    meas_ack = 1'b1;
    tick();
    abort = 1'b0;
    meas_ack = 1'b0;
    check("s5_busy", busy, 1'b0);
    check("s5_req", meas_req, 1'b0);
    check("s5_idx", point_idx, 16'd0);
    tick(3);
    check("s5_wen_count", wen_q.size(), 1);
    check("s5_no_done", done_cnt, 0);

    // Measurement with no ack.
    set_cfg(32'h300, 32'h1, 2, 0);
    clear_log();
    pulse_start();
    wait_req("s6_req");
    cnt = 0;
`ifdef SWEEP_SCHED_TIMEOUT_EN
    while (meas_req && cnt < 200) begin
      cnt++;
      tick();
    end
    check("s6_meas_cycles", cnt, TMO);
    check("s6_tmo_err", tmo_err, 1'b1);
    check("s6_busy", busy, 1'b0);
    check("s6_no_done", done_cnt, 0);
    tick(2);
    pulse_start();
    check("s6_tmo_cleared", tmo_err, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    while (meas_req && cnt < 120) begin
      cnt++;
      tick();
    end
    check("s6_still_waiting", cnt, 120);
    check("s6_tmo_tied", tmo_err, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s6_abort_idle", busy, 1'b0);
`endif
    tick(2);

    // Reset mid-sweep.
    set_cfg(32'h900, 32'h8, 3, 2);
    clear_log();
    pulse_start();
    tick(3);
    rstn = 1'b0;
    tick();
    check("s7_busy", busy, 1'b0);
    check("s7_fword", fword_out, 32'h0);
    check("s7_idx", point_idx, 16'd0);
    rstn = 1'b1;
    tick(4);
    check("s7_no_done", done_cnt, 0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
